// File: rtl/flappy_pkg.sv
// Shared constants, state encoding and pipe geometry helpers for the pipe game controller.
package flappy_pkg;

    localparam int NUM_PIPES     = 2;
    localparam int PIPE_W        = 50;
    localparam int GAP_H         = 120;
    localparam int SPACING       = 320;
    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int SPEED         = 2;
    localparam int GAP_MIN       = 60;
    localparam int GAP_MAX       = 300;
    localparam int LIVES_INIT    = 3;
    localparam int INVULN_FRAMES = 60;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_PLAY = 2'd1,
        GS_HIT  = 2'd2,
        GS_OVER = 2'd3
    } game_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 of a left-shifting Fibonacci register.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [10:0] pipe_x_init(input int idx);
        return 11'(SCREEN_W + idx * SPACING);
    endfunction

    function automatic logic pipe_col_overlap(
        input logic [10:0] ball_x,
        input logic [10:0] ball_sz,
        input logic [10:0] pipe_x
    );
        return (ball_x < (pipe_x + 11'(PIPE_W))) && ((ball_x + ball_sz) > pipe_x);
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter that sticks at 9999; clear acts as a synchronous restart.
module bcd_counter4 (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] r_count;
    logic [15:0] w_count_inc;
    logic        w_carry;

    // Ripple the +1 through the digits unless already saturated.
    always_comb begin
        w_count_inc = r_count;
        w_carry     = 1'b1;
        if (r_count == 16'h9999) begin
            w_count_inc = r_count;
        end else begin
            for (int d = 0; d < 4; d++) begin
                if (w_carry) begin
                    if (r_count[4*d +: 4] >= 4'd9) begin
                        w_count_inc[4*d +: 4] = 4'd0;
                    end else begin
                        w_count_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                        w_carry               = 1'b0;
                    end
                end else begin
                    w_count_inc[4*d +: 4] = r_count[4*d +: 4];
                end
            end
        end
    end

    // Count register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= 16'h0000;
        end else if (clear) begin
            r_count <= 16'h0000;
        end else if (inc) begin
            r_count <= w_count_inc;
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_game_scheduler.sv
// Per-frame game controller: pipe scrolling/respawn, collision, lives and BCD score.
module pipe_game_scheduler
    import flappy_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_clk,
    input  logic                    Start,
    input  logic [9:0]              BallX,
    input  logic [9:0]              BallY,
    input  logic [9:0]              Ball_size,
    output logic [NUM_PIPES*11-1:0] Pipe_X,
    output logic [NUM_PIPES*10-1:0] Gap_Y,
    output logic [15:0]             Score_BCD,
    output logic [1:0]              Lives,
    output logic [1:0]              Game_State,
    output logic                    Invuln,
    output logic                    Score_pulse,
    output logic                    Hit_pulse
);

    localparam logic [1:0]  S_IDLE      = GS_IDLE;
    localparam logic [1:0]  S_PLAY      = GS_PLAY;
    localparam logic [1:0]  S_HIT       = GS_HIT;
    localparam logic [1:0]  S_OVER      = GS_OVER;
    localparam logic [10:0] SPEED_X     = 11'(SPEED);
    localparam logic [10:0] RESPAWN_ADD = 11'(NUM_PIPES * SPACING - SPEED);
    localparam logic [10:0] PIPE_W_X    = 11'(PIPE_W);
    localparam logic [10:0] GAP_H_X     = 11'(GAP_H);
    localparam logic [10:0] SCREEN_H_X  = 11'(SCREEN_H);
    localparam logic [9:0]  GAP_MIN_G   = 10'(GAP_MIN);
    localparam logic [9:0]  GAP_MAX_G   = 10'(GAP_MAX);
    localparam logic [9:0]  GAP_RESET   = 10'd180;
    localparam logic [1:0]  LIVES_RST   = 2'(LIVES_INIT);
    localparam logic [5:0]  INVULN_LOAD = 6'(INVULN_FRAMES);

    logic                           r_fsync1, r_fsync2, r_fprev;
    logic                           w_tick;
    logic [15:0]                    r_lfsr, w_lfsr_shift, w_lfsr_next;
    logic [NUM_PIPES-1:0][10:0]     r_pipe_x, w_pipe_x_next;
    logic [NUM_PIPES-1:0][9:0]      r_gap_y, w_gap_y_next;
    logic [NUM_PIPES-1:0]           r_passed, w_passed_next, w_pipe_score, w_pipe_col;
    logic [1:0]                     r_state, w_state_next, r_lives, w_lives_next;
    logic [5:0]                     r_inv_cnt, w_inv_cnt_next;
    logic                           r_invuln, r_score_pulse, r_hit_pulse;
    logic                           w_start, w_run, w_floor, w_any_hit, w_any_score;
    logic [10:0]                    w_ball_x, w_ball_y, w_ball_sz, w_ball_bot;
    logic [9:0]                     w_gap_raw, w_gap_rand;
    logic [15:0]                    w_score_bcd;

    assign w_tick       = r_fsync2 & ~r_fprev;
    assign w_lfsr_shift = {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    assign w_lfsr_next  = (w_lfsr_shift == 16'h0000) ? LFSR_SEED : w_lfsr_shift;
    assign w_ball_x     = {1'b0, BallX};
    assign w_ball_y     = {1'b0, BallY};
    assign w_ball_sz    = {1'b0, Ball_size};
    assign w_ball_bot   = w_ball_y + w_ball_sz;
    assign w_gap_raw    = GAP_MIN_G + {2'b00, r_lfsr[7:0]};
    assign w_gap_rand   = (w_gap_raw > GAP_MAX_G) ? (w_gap_raw - 10'd128) : w_gap_raw;
    assign w_start      = Start & ((r_state == S_IDLE) | (r_state == S_OVER));
    assign w_run        = w_tick & ((r_state == S_PLAY) | (r_state == S_HIT));
    assign w_floor      = (w_ball_bot >= SCREEN_H_X);
    assign w_any_hit    = w_tick & (r_state == S_PLAY) & ((|w_pipe_col) | w_floor);
    assign w_any_score  = |w_pipe_score;

    // Per-pipe move/respawn, scoring and collision, all judged on pre-move values.
    always_comb begin
        w_pipe_x_next = r_pipe_x;
        w_gap_y_next  = r_gap_y;
        w_passed_next = r_passed;
        w_pipe_score  = '0;
        w_pipe_col    = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (w_start) begin
                w_pipe_x_next[i] = pipe_x_init(i);
                w_gap_y_next[i]  = GAP_RESET;
                w_passed_next[i] = 1'b0;
            end else if (w_run) begin
                if (!r_passed[i] && ((r_pipe_x[i] + PIPE_W_X) < w_ball_x)) begin
                    w_passed_next[i] = 1'b1;
                    w_pipe_score[i]  = 1'b1;
                end else begin
                    w_passed_next[i] = r_passed[i];
                end
                // A respawning pipe is a fresh column, so its passed flag restarts.
                if (r_pipe_x[i] >= SPEED_X) begin
                    w_pipe_x_next[i] = r_pipe_x[i] - SPEED_X;
                end else begin
                    w_pipe_x_next[i] = r_pipe_x[i] + RESPAWN_ADD;
                    w_gap_y_next[i]  = w_gap_rand;
                    w_passed_next[i] = 1'b0;
                end
                w_pipe_col[i] = pipe_col_overlap(w_ball_x, w_ball_sz, r_pipe_x[i]) &&
                                ((w_ball_y < {1'b0, r_gap_y[i]}) ||
                                 (w_ball_bot > ({1'b0, r_gap_y[i]} + GAP_H_X)));
            end else begin
                w_pipe_x_next[i] = r_pipe_x[i];
            end
        end
    end

    // Game state machine, lives and invulnerability countdown.
    always_comb begin
        w_state_next   = r_state;
        w_lives_next   = r_lives;
        w_inv_cnt_next = r_inv_cnt;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (Start) begin
                    w_state_next = S_PLAY;
                    w_lives_next = LIVES_RST;
                end else begin
                    w_state_next = r_state;
                end
            end
            S_PLAY: begin
                if (w_any_hit) begin
                    if (r_lives <= 2'd1) begin
                        w_lives_next = 2'd0;
                        w_state_next = S_OVER;
                    end else begin
                        w_lives_next   = r_lives - 2'd1;
                        w_state_next   = S_HIT;
                        w_inv_cnt_next = INVULN_LOAD;
                    end
                end else begin
                    w_state_next = S_PLAY;
                end
            end
            S_HIT: begin
                if (w_tick) begin
                    if (r_inv_cnt <= 6'd1) begin
                        w_inv_cnt_next = 6'd0;
                        w_state_next   = S_PLAY;
                    end else begin
                        w_inv_cnt_next = r_inv_cnt - 6'd1;
                    end
                end else begin
                    w_inv_cnt_next = r_inv_cnt;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Frame-edge synchronizer and free-running LFSR.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fsync1 <= 1'b0;
            r_fsync2 <= 1'b0;
            r_fprev  <= 1'b0;
            r_lfsr   <= LFSR_SEED;
        end else begin
            r_fsync1 <= frame_clk;
            r_fsync2 <= r_fsync1;
            r_fprev  <= r_fsync2;
            r_lfsr   <= w_lfsr_next;
        end
    end

    // Game registers and one-cycle event pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                r_pipe_x[i] <= pipe_x_init(i);
                r_gap_y[i]  <= GAP_RESET;
            end
            r_passed      <= '0;
            r_state       <= S_IDLE;
            r_lives       <= LIVES_RST;
            r_inv_cnt     <= 6'd0;
            r_invuln      <= 1'b0;
            r_score_pulse <= 1'b0;
            r_hit_pulse   <= 1'b0;
        end else begin
            r_pipe_x      <= w_pipe_x_next;
            r_gap_y       <= w_gap_y_next;
            r_passed      <= w_passed_next;
            r_state       <= w_state_next;
            r_lives       <= w_lives_next;
            r_inv_cnt     <= w_inv_cnt_next;
            r_invuln      <= (w_state_next == S_HIT);
            r_score_pulse <= w_any_score;
            r_hit_pulse   <= w_any_hit;
        end
    end

    bcd_counter4 u_score (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clear   (w_start),
        .inc     (w_any_score),
        .count   (w_score_bcd)
    );

    assign Pipe_X      = r_pipe_x;
    assign Gap_Y       = r_gap_y;
    assign Score_BCD   = w_score_bcd;
    assign Lives       = r_lives;
    assign Game_State  = r_state;
    assign Invuln      = r_invuln;
    assign Score_pulse = r_score_pulse;
    assign Hit_pulse   = r_hit_pulse;

endmodule

// File: tb/tb_pipe_game_scheduler.sv
// Directed bench for pipe_game_scheduler: score/hit events are checked by a queue-driven monitor.
module tb_pipe_game_scheduler;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic        Start = 1'b0;
    logic [9:0]  BallX, BallY, Ball_size;
    logic [21:0] Pipe_X;
    logic [19:0] Gap_Y;
    logic [15:0] Score_BCD;
    logic [1:0]  Lives, Game_State;
    logic        Invuln, Score_pulse, Hit_pulse;

    typedef struct packed {
        logic [1:0] lives;
        logic [1:0] state;
        logic       invuln;
    } hit_exp_t;

    logic [15:0] exp_score_q[$];
    hit_exp_t    exp_hit_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    pipe_game_scheduler dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_clk   (frame_clk),
        .Start       (Start),
        .BallX       (BallX),
        .BallY       (BallY),
        .Ball_size   (Ball_size),
        .Pipe_X      (Pipe_X),
        .Gap_Y       (Gap_Y),
        .Score_BCD   (Score_BCD),
        .Lives       (Lives),
        .Game_State  (Game_State),
        .Invuln      (Invuln),
        .Score_pulse (Score_pulse),
        .Hit_pulse   (Hit_pulse)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every event pulse pops the next expected outcome.
    always @(negedge Clk) begin
        if (Reset_n && Score_pulse) begin
            if (exp_score_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_score_pulse: got score %0h expected no pulse", Score_BCD);
            end else begin
                check("score_on_pulse", {16'h0, Score_BCD}, {16'h0, exp_score_q.pop_front()});
            end
        end
        if (Reset_n && Hit_pulse) begin
            if (exp_hit_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_hit_pulse: got lives %0d state %0d expected no pulse", Lives, Game_State);
            end else begin
                check("lives_state_invuln_on_hit", {27'h0, Lives, Game_State, Invuln}, {27'h0, exp_hit_q.pop_front()});
            end
        end
    end

    task automatic steer();
        logic [10:0] px;
        for (int i = 0; i < 2; i++) begin
            px = Pipe_X[11*i +: 11];
            if (px >= 11'd330 && px <= 11'd470) BallY = Gap_Y[10*i +: 10] + 10'd50;
        end
    endtask

    task automatic do_tick(input bit steer_en);
        if (steer_en) steer();
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pipe_x"}, {10'h0, Pipe_X}, {10'h0, 11'd960, 11'd640});
        check({tag, "_gap_y"}, {12'h0, Gap_Y}, {12'h0, 10'd180, 10'd180});
        check({tag, "_score"}, {16'h0, Score_BCD}, 32'h0);
        check({tag, "_lives"}, {30'h0, Lives}, 32'd3);
        check({tag, "_state"}, {30'h0, Game_State}, 32'd0);
        check({tag, "_pulses_invuln"}, {29'h0, Invuln, Score_pulse, Hit_pulse}, 32'd0);
    endtask

    initial begin
        BallX = 10'd100; BallY = 10'd200; Ball_size = 10'd20;
        repeat (3) @(negedge Clk);
        check_reset("reset");
        Reset_n = 1'b1;
        @(negedge Clk);

        pulse_start();
        check("start_state", {30'h0, Game_State}, 32'd1);
        check("start_pipe_x", {10'h0, Pipe_X}, {10'h0, 11'd960, 11'd640});
        check("start_lives", {30'h0, Lives}, 32'd3);
        check("start_score", {16'h0, Score_BCD}, 32'h0);

        // Scroll pipe0 to the left edge; it passes the ball once at tick 297.
        exp_score_q.push_back(16'h0001);
        repeat (320) do_tick(1'b0);
        check("pipe_x_at_edge", {10'h0, Pipe_X}, {10'h0, 11'd320, 11'd0});
        do_tick(1'b0);
        check("pipe_x_respawn", {10'h0, Pipe_X}, {10'h0, 11'd318, 11'd638});
        check("gap0_in_range", {31'h0, (Gap_Y[9:0] >= 10'd60) && (Gap_Y[9:0] <= 10'd300)}, 32'd1);
        check("gap1_unchanged", {22'h0, Gap_Y[19:10]}, 32'd180);
        check("score_after_pass", {16'h0, Score_BCD}, 32'h0001);
        check("score_q_drained", exp_score_q.size(), 32'd0);

        // Floor hits: three lives lost with 60 invulnerable ticks between them.
        BallX = 10'd0; BallY = 10'd470;
        exp_hit_q.push_back('{lives: 2'd2, state: 2'd2, invuln: 1'b1});
        exp_hit_q.push_back('{lives: 2'd1, state: 2'd2, invuln: 1'b1});
        exp_hit_q.push_back('{lives: 2'd0, state: 2'd3, invuln: 1'b0});
        do_tick(1'b0);
        check("hit1_state", {30'h0, Game_State}, 32'd2);
        check("hit1_invuln", {31'h0, Invuln}, 32'd1);
        repeat (59) do_tick(1'b0);
        check("hit_window_state", {30'h0, Game_State}, 32'd2);
        check("hit_window_lives", {30'h0, Lives}, 32'd2);
        do_tick(1'b0);
        check("back_to_play", {30'h0, Game_State}, 32'd1);
        check("back_to_play_invuln", {31'h0, Invuln}, 32'd0);
        do_tick(1'b0);
        check("hit2_lives", {30'h0, Lives}, 32'd1);
        repeat (60) do_tick(1'b0);
        do_tick(1'b0);
        check("over_state", {30'h0, Game_State}, 32'd3);
        check("over_lives", {30'h0, Lives}, 32'd0);
        check("over_pipe_x", {10'h0, Pipe_X}, {10'h0, 11'd72, 11'd392});
        check("hit_q_drained", exp_hit_q.size(), 32'd0);
        repeat (10) do_tick(1'b0);
        check("frozen_pipe_x", {10'h0, Pipe_X}, {10'h0, 11'd72, 11'd392});
        check("frozen_state", {30'h0, Game_State}, 32'd3);

        // Start lands in the same Clk as a frame tick: restart wins, no scroll.
        BallX = 10'd400; BallY = 10'd200;
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        check("restart_state", {30'h0, Game_State}, 32'd1);
        check("restart_pipe_x", {10'h0, Pipe_X}, {10'h0, 11'd960, 11'd640});
        check("restart_gap_y", {12'h0, Gap_Y}, {12'h0, 10'd180, 10'd180});
        check("restart_lives", {30'h0, Lives}, 32'd3);
        check("restart_score", {16'h0, Score_BCD}, 32'h0);

        // Saturation: preload 9998, then three passes at ticks 147, 307 and 467.
        force dut.u_score.r_count = 16'h9998;
        #1;
        release dut.u_score.r_count;
        @(negedge Clk);
        check("preload_score", {16'h0, Score_BCD}, 32'h9998);
        exp_score_q.push_back(16'h9999);
        exp_score_q.push_back(16'h9999);
        exp_score_q.push_back(16'h9999);
        repeat (470) do_tick(1'b1);
        check("saturated_score", {16'h0, Score_BCD}, 32'h9999);
        check("sat_score_q_drained", exp_score_q.size(), 32'd0);
        check("sat_lives_kept", {30'h0, Lives}, 32'd3);
        check("sat_pipe_x", {10'h0, Pipe_X}, {10'h0, 11'd20, 11'd340});

        // Enter HIT, then pull reset asynchronously.
        BallY = 10'd470;
        exp_hit_q.push_back('{lives: 2'd2, state: 2'd2, invuln: 1'b1});
        do_tick(1'b0);
        check("final_hit_state", {30'h0, Game_State}, 32'd2);
        check("final_hit_q_drained", exp_hit_q.size(), 32'd0);
        Reset_n = 1'b0;
        #1;
        check_reset("async_reset");
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
